// File: rtl/alu_apb_master_if.sv
// Job request, result response and APB requester signals of alu_apb_master, bundled as one port.
// The master modport is the requester side; the slave modport is the host plus CSR slave side.
interface alu_apb_master_if #(
    parameter int ADDR_WIDTH     = 3,
    parameter int APB_BUS_SIZE   = 32,
    parameter int OPERAND_SIZE   = 12,
    parameter int OPERATION_SIZE = 2,
    parameter int FIFO_OUT_WIDTH = 25
);
    logic                      job_valid;
    logic                      job_ready;
    logic [OPERATION_SIZE-1:0] job_op;
    logic [OPERAND_SIZE-1:0]   job_data0;
    logic [OPERAND_SIZE-1:0]   job_data1;

    logic                      res_valid;
    logic                      res_ready;
    logic [FIFO_OUT_WIDTH-1:0] res_data;
    logic [1:0]                res_err;

    logic [ADDR_WIDTH-1:0]     addr;
    logic                      sel;
    logic                      en;
    logic                      write;
    logic [APB_BUS_SIZE-1:0]   wdata;
    logic [OPERATION_SIZE-1:0] ctrl_op;
    logic [APB_BUS_SIZE-1:0]   rdata;
    logic                      ready;
    logic                      slv_err;

    modport master (
        input  job_valid, job_op, job_data0, job_data1, res_ready, rdata, ready, slv_err,
        output job_ready, res_valid, res_data, res_err, addr, sel, en, write, wdata, ctrl_op
    );

    modport slave (
        output job_valid, job_op, job_data0, job_data1, res_ready, rdata, ready, slv_err,
        input  job_ready, res_valid, res_data, res_err, addr, sel, en, write, wdata, ctrl_op
    );
endinterface

// File: rtl/alu_apb_master.sv
// APB requester for the ALU CSR slave: per job it writes both operands and the start command,
// then polls REG_RES with spaced retries until a result arrives or an error ends the job.
module alu_apb_master #(
    parameter int ADDR_WIDTH     = 3,
    parameter int APB_BUS_SIZE   = 32,
    parameter int OPERAND_SIZE   = 12,
    parameter int OPERATION_SIZE = 2,
    parameter int FIFO_OUT_WIDTH = 25,
    parameter int REG_CTRL       = 0,
    parameter int REG_0          = 1,
    parameter int REG_1          = 2,
    parameter int REG_RES        = 3,
    parameter int RETRY_MAX      = 8,
    parameter int RETRY_GAP      = 4,
    parameter int WAIT_MAX       = 16
) (
    input logic              clk,
    input logic              rst_n,
    alu_apb_master_if.master bus
);
    localparam int RETRY_W = $clog2(RETRY_MAX + 1);
    localparam int WAIT_W  = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
    localparam int GAP_W   = (RETRY_GAP > 1) ? $clog2(RETRY_GAP) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_GAP,
        S_RWAIT,
        S_DONE
    } state_t;

    state_t                    r_state,   w_stateNext;
    logic [1:0]                r_step,    w_stepNext;
    logic [RETRY_W-1:0]        r_retry,   w_retryNext;
    logic [WAIT_W-1:0]         r_wait,    w_waitNext;
    logic [GAP_W-1:0]          r_gap,     w_gapNext;
    logic [OPERATION_SIZE-1:0] r_op,      w_opNext;
    logic [OPERAND_SIZE-1:0]   r_data0,   w_data0Next;
    logic [OPERAND_SIZE-1:0]   r_data1,   w_data1Next;
    logic [FIFO_OUT_WIDTH-1:0] r_resData, w_resDataNext;
    logic [1:0]                r_resErr,  w_resErrNext;

    logic                      w_busActive;
    logic                      w_isRead;
    logic [RETRY_W-1:0]        w_retryInc;
    logic [ADDR_WIDTH-1:0]     w_stepAddr;
    logic [APB_BUS_SIZE-1:0]   w_stepWdata;

    // Address and payload of the transfer belonging to the current step.
    always_comb begin
        w_stepAddr  = ADDR_WIDTH'(REG_RES);
        w_stepWdata = '0;
        case (r_step)
            2'd0: begin
                w_stepAddr  = ADDR_WIDTH'(REG_0);
                w_stepWdata = APB_BUS_SIZE'(r_data0);
            end
            2'd1: begin
                w_stepAddr  = ADDR_WIDTH'(REG_1);
                w_stepWdata = APB_BUS_SIZE'(r_data1);
            end
            2'd2: begin
                w_stepAddr  = ADDR_WIDTH'(REG_CTRL);
                w_stepWdata = APB_BUS_SIZE'({1'b1, r_op});
            end
            default: ;
        endcase
    end

    assign w_isRead    = (r_step == 2'd3);
    assign w_busActive = (r_state == S_SETUP) || (r_state == S_ACCESS);
    assign w_retryInc  = r_retry + 1'b1;

    // Bus outputs decode straight from state so a reset pulls sel/en low without waiting for a clock.
    assign bus.sel       = w_busActive;
    assign bus.en        = (r_state == S_ACCESS);
    assign bus.addr      = w_busActive ? w_stepAddr : '0;
    assign bus.write     = w_busActive & ~w_isRead;
    assign bus.wdata     = w_busActive ? w_stepWdata : '0;
    assign bus.ctrl_op   = (r_state != S_IDLE) ? r_op : '0;
    assign bus.job_ready = (r_state == S_IDLE);
    assign bus.res_valid = (r_state == S_DONE);
    assign bus.res_data  = r_resData;
    assign bus.res_err   = r_resErr;

    always_comb begin
        w_stateNext   = r_state;
        w_stepNext    = r_step;
        w_retryNext   = r_retry;
        w_waitNext    = r_wait;
        w_gapNext     = r_gap;
        w_opNext      = r_op;
        w_data0Next   = r_data0;
        w_data1Next   = r_data1;
        w_resDataNext = r_resData;
        w_resErrNext  = r_resErr;

        case (r_state)
            S_IDLE: begin
                if (bus.job_valid) begin
                    w_opNext      = bus.job_op;
                    w_data0Next   = bus.job_data0;
                    w_data1Next   = bus.job_data1;
                    w_stepNext    = 2'd0;
                    w_retryNext   = '0;
                    w_resDataNext = '0;
                    w_resErrNext  = 2'b00;
                    w_stateNext   = S_SETUP;
                end
            end

            S_SETUP: begin
                w_waitNext  = '0;
                w_stateNext = S_ACCESS;
            end

            // rdata and slv_err are only meaningful in the cycle ready is high.
            S_ACCESS: begin
                if (bus.ready) begin
                    if (!w_isRead) begin
                        if (bus.slv_err) begin
                            w_resErrNext = 2'b01;
                            w_stateNext  = S_DONE;
                        end else begin
                            w_stepNext  = r_step + 2'd1;
                            w_stateNext = S_GAP;
                        end
                    end else if (!bus.slv_err) begin
                        w_resDataNext = bus.rdata[FIFO_OUT_WIDTH-1:0];
                        w_resErrNext  = 2'b00;
                        w_stateNext   = S_DONE;
                    end else begin
                        w_retryNext = w_retryInc;
                        if (w_retryInc == RETRY_W'(RETRY_MAX)) begin
                            w_resDataNext = '0;
                            w_resErrNext  = 2'b10;
                            w_stateNext   = S_DONE;
                        end else begin
                            w_gapNext   = '0;
                            w_stateNext = S_RWAIT;
                        end
                    end
                end else if (r_wait == WAIT_W'(WAIT_MAX - 1)) begin
                    w_resErrNext = 2'b11;
                    w_stateNext  = S_DONE;
                end else begin
                    w_waitNext = r_wait + 1'b1;
                end
            end

            // The slave edge-detects sel, so every transfer is followed by at least one deselected cycle.
            S_GAP: begin
                w_stateNext = S_SETUP;
            end

            S_RWAIT: begin
                if (r_gap == GAP_W'(RETRY_GAP - 1)) begin
                    w_stateNext = S_SETUP;
                end else begin
                    w_gapNext = r_gap + 1'b1;
                end
            end

            S_DONE: begin
                if (bus.res_ready) begin
                    w_stateNext = S_IDLE;
                end
            end

            default: begin
                w_stateNext = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_step    <= '0;
            r_retry   <= '0;
            r_wait    <= '0;
            r_gap     <= '0;
            r_op      <= '0;
            r_data0   <= '0;
            r_data1   <= '0;
            r_resData <= '0;
            r_resErr  <= '0;
        end else begin
            r_state   <= w_stateNext;
            r_step    <= w_stepNext;
            r_retry   <= w_retryNext;
            r_wait    <= w_waitNext;
            r_gap     <= w_gapNext;
            r_op      <= w_opNext;
            r_data0   <= w_data0Next;
            r_data1   <= w_data1Next;
            r_resData <= w_resDataNext;
            r_resErr  <= w_resErrNext;
        end
    end
endmodule

// File: tb/tb_alu_apb_master.sv
// Bench for alu_apb_master: a scripted CSR slave answers each transfer, and a transaction-level
// model predicts the transfer list and the job result from the job and slave behaviour.
module tb_alu_apb_master;
    localparam int ADDR_WIDTH     = 3;
    localparam int APB_BUS_SIZE   = 32;
    localparam int OPERAND_SIZE   = 12;
    localparam int OPERATION_SIZE = 2;
    localparam int FIFO_OUT_WIDTH = 25;
    localparam int REG_CTRL       = 0;
    localparam int REG_0          = 1;
    localparam int REG_1          = 2;
    localparam int REG_RES        = 3;
    localparam int RETRY_MAX      = 8;
    localparam int RETRY_GAP      = 4;
    localparam int WAIT_MAX       = 16;
    localparam int CYCLE_BUDGET   = 2000;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alu_apb_master_if #(
        .ADDR_WIDTH(ADDR_WIDTH), .APB_BUS_SIZE(APB_BUS_SIZE), .OPERAND_SIZE(OPERAND_SIZE),
        .OPERATION_SIZE(OPERATION_SIZE), .FIFO_OUT_WIDTH(FIFO_OUT_WIDTH)
    ) bus ();

    alu_apb_master #(
        .ADDR_WIDTH(ADDR_WIDTH), .APB_BUS_SIZE(APB_BUS_SIZE), .OPERAND_SIZE(OPERAND_SIZE),
        .OPERATION_SIZE(OPERATION_SIZE), .FIFO_OUT_WIDTH(FIFO_OUT_WIDTH),
        .REG_CTRL(REG_CTRL), .REG_0(REG_0), .REG_1(REG_1), .REG_RES(REG_RES),
        .RETRY_MAX(RETRY_MAX), .RETRY_GAP(RETRY_GAP), .WAIT_MAX(WAIT_MAX)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // One job plus how the slave treats it; -1 in a step field means "never".
    typedef struct {
        logic [1:0]  op;
        logic [11:0] d0;
        logic [11:0] d1;
        int          writeErrStep;
        int          readErrs;
        logic [31:0] readData;
        int          delay;
        int          timeoutStep;
        int          hold;
        logic [1:0]  expErr;
        logic [24:0] expData;
        int          expXfers;
    } jobT;

    typedef struct packed {
        logic [2:0]  addr;
        logic        wr;
        logic [31:0] wdata;
    } xferT;

    int   total = 0;
    int   bad   = 0;
    xferT expQ[$];
    xferT obsQ[$];
    int   gapQ[$];
    jobT  vec[11];

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic jobT mk(input logic [1:0] op, input logic [11:0] d0, input logic [11:0] d1,
                               input int wErr, input int rErrs, input logic [31:0] rData,
                               input int delay, input int tStep, input int hold,
                               input logic [1:0] eErr, input logic [24:0] eData, input int eXfers);
        jobT j;
        j.op = op; j.d0 = d0; j.d1 = d1;
        j.writeErrStep = wErr; j.readErrs = rErrs; j.readData = rData;
        j.delay = delay; j.timeoutStep = tStep; j.hold = hold;
        j.expErr = eErr; j.expData = eData; j.expXfers = eXfers;
        return j;
    endfunction

    function automatic int stepOf(input logic [2:0] a);
        if (a == 3'(REG_0))   return 0;
        if (a == 3'(REG_1))   return 1;
        if (a == 3'(REG_CTRL)) return 2;
        if (a == 3'(REG_RES)) return 3;
        return 7;
    endfunction

    // Transaction-level model: list of transfers the job must produce, and its final result.
    task automatic buildExpect(input jobT j, output logic [1:0] err, output logic [24:0] data);
        xferT w[4];
        w[0].addr = 3'(REG_0);    w[0].wr = 1'b1; w[0].wdata = 32'(j.d0);
        w[1].addr = 3'(REG_1);    w[1].wr = 1'b1; w[1].wdata = 32'(j.d1);
        w[2].addr = 3'(REG_CTRL); w[2].wr = 1'b1; w[2].wdata = 32'(j.op) + 32'd4;
        w[3].addr = 3'(REG_RES);  w[3].wr = 1'b0; w[3].wdata = 32'd0;
        expQ.delete();
        err  = 2'b00;
        data = '0;
        for (int s = 0; s < 3; s++) begin
            expQ.push_back(w[s]);
            if (j.timeoutStep == s)  begin err = 2'b11; return; end
            if (j.writeErrStep == s) begin err = 2'b01; return; end
        end
        for (int a = 0; a < RETRY_MAX; a++) begin
            expQ.push_back(w[3]);
            if (j.timeoutStep == 3) begin err = 2'b11; return; end
            if (a >= j.readErrs) begin data = j.readData[24:0]; return; end
        end
        err = 2'b10;
    endtask

    function automatic jobT randomJob();
        jobT j;
        int  kind;
        j.op = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
        j.d0 = 12'($urandom);
        j.d1 = 12'($urandom);
        j.readData = $urandom;
        j.writeErrStep = -1;
        j.timeoutStep = -1;
        j.readErrs = int'($urandom_range(0, 2));
        j.delay = ($urandom_range(0, 7) == 0) ? 15 : int'($urandom_range(0, 3));
        j.hold = int'($urandom_range(0, 5));
        kind = int'($urandom_range(0, 9));
        case (kind)
            5: j.writeErrStep = int'($urandom_range(0, 2));
            6: j.timeoutStep = int'($urandom_range(0, 3));
            7: j.readErrs = int'($urandom_range(RETRY_MAX, RETRY_MAX + 2));
            8: j.readErrs = int'($urandom_range(3, RETRY_MAX - 1));
            default: ;
        endcase
        j.expErr = 2'b00; j.expData = '0; j.expXfers = 0;
        return j;
    endfunction

    // Presents one job, plays the CSR slave cycle by cycle, then checks the result and its handshake.
    task automatic applyStimulus(input jobT j);
        logic [1:0]  mErr;
        logic [24:0] mData;
        logic [24:0] heldData;
        logic [1:0]  heldErr;
        xferT        cur;
        int cyc, accCnt, idleRun, readAttempt, step;
        int stableErrs, zeroErrs, opErrs, gapErrs, heldErrs, nCmp;
        bit done;

        buildExpect(j, mErr, mData);
        obsQ.delete();
        gapQ.delete();
        cur = '0;
        cyc = 0; accCnt = 0; idleRun = 0; readAttempt = 0;
        stableErrs = 0; zeroErrs = 0; opErrs = 0; gapErrs = 0; heldErrs = 0;
        done = 1'b0;

        @(negedge clk);
        bus.job_valid = 1'b1;
        bus.job_op    = j.op;
        bus.job_data0 = j.d0;
        bus.job_data1 = j.d1;
        @(posedge clk); #1;
        bus.job_valid = 1'b0;
        bus.job_op    = 2'($urandom);
        bus.job_data0 = 12'($urandom);
        bus.job_data1 = 12'($urandom);

        while (!done && cyc < CYCLE_BUDGET) begin
            if (bus.res_valid) begin
                done = 1'b1;
            end else begin
                if (bus.ctrl_op !== j.op) opErrs++;
                bus.ready   = 1'b0;
                bus.slv_err = 1'($urandom);
                bus.rdata   = $urandom;
                if (bus.sel && !bus.en) begin
                    cur = {bus.addr, bus.write, bus.wdata};
                    if (obsQ.size() > 0) gapQ.push_back(idleRun);
                    obsQ.push_back(cur);
                    idleRun = 0;
                    accCnt = 0;
                end else if (bus.sel && bus.en) begin
                    if ({bus.addr, bus.write, bus.wdata} !== cur) stableErrs++;
                    step = stepOf(bus.addr);
                    bus.ready = (step != j.timeoutStep) && (accCnt >= j.delay);
                    if (bus.ready) begin
                        if (bus.write) begin
                            bus.slv_err = (step == j.writeErrStep);
                        end else begin
                            bus.slv_err = (readAttempt < j.readErrs);
                            if (!bus.slv_err) bus.rdata = j.readData;
                            readAttempt++;
                        end
                    end
                    accCnt++;
                end else begin
                    idleRun++;
                    if ({bus.addr, bus.write, bus.wdata} !== 36'd0) zeroErrs++;
                end
                @(posedge clk); #1;
                cyc++;
            end
        end
        bus.ready = 1'b0;

        checkOutput("res_valid_seen", 64'(done), 64'd1);
        checkOutput("res_err", 64'(bus.res_err), 64'(j.expErr));
        checkOutput("res_data", 64'(bus.res_data), 64'(j.expData));
        checkOutput("xfer_count", 64'(obsQ.size()), 64'(j.expXfers));
        nCmp = (obsQ.size() < expQ.size()) ? obsQ.size() : expQ.size();
        for (int i = 0; i < nCmp; i++)
            checkOutput($sformatf("xfer%0d_addr_wr_wdata", i), 64'(obsQ[i]), 64'(expQ[i]));
        for (int g = 0; g < gapQ.size(); g++) begin
            if (!obsQ[g].wr && !obsQ[g+1].wr) begin
                if (gapQ[g] != RETRY_GAP) gapErrs++;
            end else if (gapQ[g] < 1) begin
                gapErrs++;
            end
        end
        checkOutput("idle_gaps", 64'(gapErrs), 64'd0);
        if (j.expErr == 2'b11) checkOutput("timeout_access_cycles", 64'(accCnt), 64'(WAIT_MAX));
        checkOutput("access_stable", 64'(stableErrs), 64'd0);
        checkOutput("idle_bus_zero", 64'(zeroErrs), 64'd0);
        checkOutput("ctrl_op_held", 64'(opErrs), 64'd0);
        checkOutput("job_ready_in_done", 64'(bus.job_ready), 64'd0);

        heldData = bus.res_data;
        heldErr  = bus.res_err;
        bus.res_ready = 1'b0;
        bus.job_valid = 1'b1;
        bus.job_op    = 2'b01;
        for (int k = 0; k < j.hold; k++) begin
            @(posedge clk); #1;
            if (!bus.res_valid || bus.res_data !== heldData || bus.res_err !== heldErr ||
                bus.job_ready || bus.sel) heldErrs++;
        end
        checkOutput("done_hold_stable", 64'(heldErrs), 64'd0);
        bus.res_ready = 1'b1;
        @(posedge clk); #1;
        bus.res_ready = 1'b0;
        checkOutput("after_consume_idle", 64'({bus.res_valid, bus.job_ready, bus.sel, bus.ctrl_op}),
                    64'({1'b0, 1'b1, 1'b0, 2'b00}));
        bus.job_valid = 1'b0;
    endtask

    task automatic resetMidAccess();
        bit found;
        int quiet;
        found = 1'b0;
        quiet = 0;
        @(negedge clk);
        bus.job_valid = 1'b1;
        bus.job_op    = 2'b10;
        bus.job_data0 = 12'h111;
        bus.job_data1 = 12'h222;
        @(posedge clk); #1;
        bus.job_valid = 1'b0;
        for (int k = 0; k < 50 && !found; k++) begin
            if (bus.sel && bus.en && bus.addr == 3'(REG_1)) begin
                found = 1'b1;
            end else begin
                bus.ready   = bus.sel && bus.en;
                bus.slv_err = 1'b0;
                @(posedge clk); #1;
            end
        end
        checkOutput("reached_step1_access", 64'(found), 64'd1);
        bus.ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("reset_drops_sel_en", 64'({bus.sel, bus.en}), 64'd0);
        checkOutput("reset_no_res_valid", 64'(bus.res_valid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) begin
            @(posedge clk); #1;
            if (bus.sel || bus.res_valid) quiet++;
        end
        checkOutput("post_reset_idle", 64'({bus.job_ready, bus.res_valid}), 64'({1'b1, 1'b0}));
        checkOutput("post_reset_quiet", 64'(quiet), 64'd0);
    endtask

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        jobT         j;
        logic [1:0]  mErr;
        logic [24:0] mData;

        vec[0]  = mk(2'b01, 12'h00A, 12'h005, -1, 0, 32'h0000000F,  0, -1, 5, 2'b00, 25'h000000F, 4);
        vec[1]  = mk(2'b10, 12'h123, 12'hFFF, -1, 2, 32'h00001234,  1, -1, 1, 2'b00, 25'h0001234, 6);
        vec[2]  = mk(2'b01, 12'h0AB, 12'h0CD,  1, 0, 32'h00000055,  0, -1, 0, 2'b01, 25'h0,       2);
        vec[3]  = mk(2'b10, 12'h001, 12'h002, -1, 0, 32'h00000077,  0,  0, 2, 2'b11, 25'h0,       1);
        vec[4]  = mk(2'b01, 12'h3FF, 12'h400, -1, 8, 32'h00000099,  0, -1, 0, 2'b10, 25'h0,       11);
        vec[5]  = mk(2'b10, 12'hFFF, 12'hFFF, -1, 0, 32'hFFFFFFFF,  3, -1, 1, 2'b00, 25'h1FFFFFF, 4);
        vec[6]  = mk(2'b01, 12'h800, 12'h001,  2, 0, 32'h00000005,  0, -1, 0, 2'b01, 25'h0,       3);
        vec[7]  = mk(2'b10, 12'h010, 12'h020, -1, 7, 32'h000ABCDE,  0, -1, 0, 2'b00, 25'h00ABCDE, 11);
        vec[8]  = mk(2'b01, 12'h100, 12'h200, -1, 0, 32'h00000044,  0,  3, 0, 2'b11, 25'h0,       4);
        vec[9]  = mk(2'b10, 12'h7FF, 12'h000,  0, 0, 32'h00000001,  0, -1, 0, 2'b01, 25'h0,       1);
        vec[10] = mk(2'b01, 12'h456, 12'h789, -1, 1, 32'h01FEDCBA, 15, -1, 0, 2'b00, 25'h1FEDCBA, 5);

        rst_n         = 1'b0;
        bus.job_valid = 1'b0;
        bus.job_op    = '0;
        bus.job_data0 = '0;
        bus.job_data1 = '0;
        bus.res_ready = 1'b0;
        bus.rdata     = '0;
        bus.ready     = 1'b0;
        bus.slv_err   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_apb_outputs", 64'({bus.sel, bus.en, bus.addr, bus.write, bus.wdata}), 64'd0);
        checkOutput("reset_res_outputs", 64'({bus.res_valid, bus.res_data, bus.res_err, bus.ctrl_op}), 64'd0);
        checkOutput("reset_job_ready", 64'(bus.job_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            $display("[TB] table vector %0d", i);
            applyStimulus(vec[i]);
        end

        resetMidAccess();
        applyStimulus(vec[0]);

        for (int n = 0; n < 24; n++) begin
            j = randomJob();
            buildExpect(j, mErr, mData);
            j.expErr   = mErr;
            j.expData  = mData;
            j.expXfers = expQ.size();
            applyStimulus(j);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_apb_master.md
Name: alu_apb_master

Overview:
- APB requester that drives the ALU control/status register slave from a simple job interface.
- Per job, it performs a fixed transfer sequence:
  - write operand 0 to REG_0;
  - write operand 1 to REG_1;
  - write the start command to REG_CTRL;
  - read REG_RES, retrying while the slave reports an empty result FIFO.
- Sits between the test/host logic and the CSR slave, one APB transfer at a time.

Parameters:
- ADDR_WIDTH, 3, APB address width (clog2 of 5 registers).
- APB_BUS_SIZE, 32, wdata/rdata width.
- OPERAND_SIZE, 12, width of each operand, zero-extended onto wdata.
- OPERATION_SIZE, 2, opcode width.
- FIFO_OUT_WIDTH, 25, result width taken from rdata[24:0].
- REG_CTRL, 0, control register address.
- REG_0, 1, operand 0 address.
- REG_1, 2, operand 1 address.
- REG_RES, 3, result register address.
- RETRY_MAX, 8, maximum REG_RES read attempts per job.
- RETRY_GAP, 4, idle cycles between REG_RES read attempts.
- WAIT_MAX, 16, maximum ACCESS cycles waiting for ready.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- job_valid  in  1  job request
- job_ready  out  1  high in IDLE only
- job_op  in  OPERATION_SIZE  opcode, 01 or 10
- job_data0  in  OPERAND_SIZE  operand 0
- job_data1  in  OPERAND_SIZE  operand 1
- res_valid  out  1  result/status available
- res_ready  in  1  result consumed
- res_data  out  FIFO_OUT_WIDTH  result read from REG_RES
- res_err  out  2  00 ok, 01 write slv_err, 10 retries exhausted, 11 ready timeout
- addr  out  ADDR_WIDTH  APB address
- sel  out  1  APB select
- en  out  1  APB enable
- write  out  1  APB direction, 1 = write
- wdata  out  APB_BUS_SIZE  APB write data
- ctrl_op  out  OPERATION_SIZE  latched job opcode to the slave
- rdata  in  APB_BUS_SIZE  APB read data
- ready  in  1  APB ready
- slv_err  in  1  APB slave error

Behaviour:
- Reset values (async on rst_n low): state IDLE; all outputs 0; counters 0. job_ready is 1 once in IDLE (combinational from state).
- Reset mid-transfer: sel and en drop immediately; the job is lost and no res_valid is produced.
- Job acceptance: handshake on job_valid & job_ready. On acceptance, latch op, data0 and data1; step = 0; retry count = 0. job_* inputs are ignored outside the accepting cycle.
- States:
  - IDLE: if job accepted, go to SETUP.
  - SETUP (1 cycle): sel=1, en=0. addr, write and wdata are driven for the current step. Go to ACCESS.
  - ACCESS: sel=1, en=1. addr, write and wdata are held stable.
    - Wait while ready=0, counting cycles.
    - When ready=1, sample slv_err and rdata in that same cycle.
    - If the wait count reaches WAIT_MAX with ready still 0, set res_err=11 and go to DONE.
  - GAP: sel=0, en=0, for 1 cycle minimum after every transfer. This is mandatory because the slave write enables are edge-detected on sel.
  - RWAIT: sel=0 for RETRY_GAP cycles, then SETUP for the next read attempt.
  - DONE: res_valid=1, res_data/res_err held stable. Stays until res_ready=1, then IDLE. A new job cannot be accepted in the same cycle as the response is consumed.
- Step sequence:
  - step 0: write REG_0, wdata = zero-extended data0.
  - step 1: write REG_1, wdata = zero-extended data1.
  - step 2: write REG_CTRL, wdata[1:0] = op, wdata[2] = 1 (start), other bits 0.
  - step 3: read REG_RES, write=0, wdata=0.
- Completion handling:
  - Write step with slv_err=1: res_err=01; skip the remaining steps; go to DONE.
  - Write step ok: GAP, then SETUP for step+1.
  - Read step with slv_err=0: res_data = rdata[24:0], res_err=00, go to DONE.
  - Read step with slv_err=1: increment the retry count.
    - If the count equals RETRY_MAX: res_err=10, res_data=0, go to DONE.
    - Otherwise: go to RWAIT.
- Output rules:
  - ctrl_op equals the latched op for the whole job; it is 0 in IDLE.
  - addr/write/wdata are 0 whenever sel=0.

Test Plan:
- Job op=01, data0=0x00A, data1=0x005; slave returns rdata=0x000000F on the first read. Required:
  - SETUP/ACCESS pairs to addr 1, 2, 0, 3;
  - wdata 0x00A, 0x005, 0x00000005;
  - ≥1 sel=0 cycle between transfers;
  - res_valid with res_data=0x000000F, res_err=00.
- Read returns slv_err=1 twice, then ok with 0x1234. Required:
  - exactly 3 read transfers;
  - RETRY_GAP=4 idle cycles between each;
  - res_data=0x0001234, res_err=00.
- slv_err=1 on the REG_1 write. Required: no REG_CTRL or REG_RES transfer; res_err=01.
- ready held 0 for 16 ACCESS cycles on the REG_0 write. Required: sel drops; res_err=11.
- Read always slv_err=1. Required: exactly 8 read attempts; res_err=10, res_data=0.
- Reset mid-ACCESS, and response backpressure:
  - rst_n low during ACCESS of step 1: sel=en=0 immediately; after release job_ready=1 and res_valid=0.
  - res_ready held 0 for 5 cycles in DONE: res_valid/res_data stable; job_ready=0 throughout.
